meas_vec_pipe: RTL

Parametrised multi-channel register pipeline for wide measurement vectors. It carries NUM_CH channels of WIDTH bits through DEPTH elastic stages with valid/ready handshakes, and adds a trigger-armed snapshot mode, a freeze mode and beat counters. It sits between the measurement stimulus source and the capture/readout logic, in place of the fixed three-channel single-stage register.

---
 rtl/meas_vec_pipe_pkg.sv | 20 ++
 rtl/meas_vec_pipe_if.sv | 33 +++
 rtl/meas_vec_pipe_stage.sv | 46 ++++
 rtl/meas_vec_pipe.sv | 138 +++++++++++++
 4 files changed

// File: rtl/meas_vec_pipe_pkg.sv
// Shared definitions for the measurement vector pipeline: mode encodings,
// snapshot FSM state type and channel slicing helper.
package meas_pkg;

    localparam logic [1:0] MODE_STREAM   = 2'd0;
    localparam logic [1:0] MODE_SNAPSHOT = 2'd1;
    localparam logic [1:0] MODE_FREEZE   = 2'd2;
    localparam logic [1:0] MODE_RESERVED = 2'd3;

    typedef logic [0:0] snap_state_t;

    localparam snap_state_t ST_IDLE  = 1'b0;
    localparam snap_state_t ST_ARMED = 1'b1;

    // LSB of channel ch inside a packed NUM_CH*width vector.
    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned width);
        return ch * width;
    endfunction

endpackage

// File: rtl/meas_vec_pipe_if.sv
// Valid/ready bus of the measurement pipeline: input beat stream and output beat stream.
interface meas_vec_pipe_if #(
    parameter int unsigned WIDTH  = 9984,
    parameter int unsigned NUM_CH = 3
);
    localparam int unsigned DW = WIDTH * NUM_CH;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/meas_vec_pipe_stage.sv
// One valid/data register slice. Ready is computed by the parent, which
// also owns freeze gating through ld_i.
module meas_pipe_stage #(
    parameter int unsigned WIDTH  = 9984,
    parameter int unsigned NUM_CH = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      ld_i,
    input  logic                      up_valid_i,
    input  logic [WIDTH*NUM_CH-1:0]   up_data_i,
    output logic                      valid_o,
    output logic [WIDTH*NUM_CH-1:0]   data_o
);

    localparam int unsigned DW = WIDTH * NUM_CH;

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;

    // Data only moves with a valid beat so an empty slice keeps its last contents.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (ld_i) begin
            valid_d = up_valid_i;
            if (up_valid_i) begin
                data_d = up_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/meas_vec_pipe.sv
// Multi-channel elastic register pipeline with stream, trigger-armed snapshot
// and freeze modes, plus delivered-beat and dropped-beat counters.
module meas_vec_pipe
    import meas_pkg::*;
#(
    parameter int unsigned WIDTH  = 9984,
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             sys_clk_p,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             trigger,
    meas_vec_pipe_if.slave   bus,
    output logic [CNT_W-1:0] beat_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             armed
);

    localparam int unsigned DW = WIDTH * NUM_CH;

    logic             frozen;
    logic             snap;
    logic             chain_rdy;
    logic [DEPTH-1:0] stg_rdy;
    logic [DEPTH-1:0] stg_v;
    logic [DW-1:0]    stg_d [DEPTH];
    logic             head_valid;
    logic             accept;
    logic             capture;
    logic             drop;
    logic             out_hs;

    snap_state_t      state_q, state_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    always_comb begin
        frozen = (mode == MODE_FREEZE) || (mode == MODE_RESERVED);
        snap   = (mode == MODE_SNAPSHOT);
    end

    // r[k] = !v[k] || r[k+1], unrolled from the output end.
    always_comb begin
        chain_rdy = bus.out_ready && !frozen;
        stg_rdy   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            chain_rdy  = chain_rdy || !stg_v[k];
            stg_rdy[k] = chain_rdy;
        end
    end

    always_comb begin
        if (reset || frozen) begin
            bus.in_ready = 1'b0;
        end else if (snap) begin
            bus.in_ready = 1'b1;
        end else begin
            bus.in_ready = stg_rdy[0];
        end
        bus.out_valid = stg_v[DEPTH-1] && !frozen && !reset;
        bus.out_data  = stg_d[DEPTH-1];
    end

    always_comb begin
        accept     = bus.in_valid && bus.in_ready;
        capture    = snap && accept && (state_q == ST_ARMED) && stg_rdy[0];
        drop       = snap && accept && !capture;
        head_valid = snap ? (bus.in_valid && (state_q == ST_ARMED)) : bus.in_valid;
        out_hs     = bus.out_valid && bus.out_ready;
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic          up_v;
        logic [DW-1:0] up_d;

        if (k == 0) begin : g_head
            assign up_v = head_valid;
            assign up_d = bus.in_data;
        end else begin : g_body
            assign up_v = stg_v[k-1];
            assign up_d = stg_d[k-1];
        end

        meas_pipe_stage #(
            .WIDTH  (WIDTH),
            .NUM_CH (NUM_CH)
        ) u_stage (
            .clk_i      (sys_clk_p),
            .rst_i      (reset),
            .ld_i       (stg_rdy[k] && !frozen),
            .up_valid_i (up_v),
            .up_data_i  (up_d),
            .valid_o    (stg_v[k]),
            .data_o     (stg_d[k])
        );
    end

    // A trigger arriving with a beat arms first; that beat is already lost.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_IDLE) begin
            if (snap && trigger) begin
                state_d = ST_ARMED;
            end
        end else begin
            if (!snap || capture) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        beat_d = beat_q + (out_hs ? CNT_W'(1) : CNT_W'(0));
        drop_d = drop_q;
        if (drop && !(&drop_q)) begin
            drop_d = drop_q + CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk_p) begin
        if (reset) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            drop_q  <= drop_d;
        end
    end

    assign beat_count = beat_q;
    assign drop_count = drop_q;
    assign armed      = (state_q == ST_ARMED);

endmodule
